regfile_scoreboard: RTL

Parametrised architectural register file with a per-register in-flight-write scoreboard for the decode stage. It replaces the conservative "stall on any rd match in AGEX/MEM/WB" check with exact pending-write counters, so pipelines of any depth are supported. It also provides N read ports with same-cycle writeback bypass and squash ports that retire counters for flushed instructions. It sits between the FE latch decode logic and the DE latch, and is written by WB.

---
 rtl/regfile_scoreboard_if.sv | 35 +++
 rtl/regfile_scoreboard.sv | 110 +++++++++++
 2 files changed

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback/squash bundle of the register-file scoreboard.
// The slave side is the register file; the master side is the pipeline driving it.
interface regfile_scoreboard_if #(
    parameter int DBITS        = 32,
    parameter int REGNOBITS    = 5,
    parameter int NUM_RD_PORTS = 2,
    parameter int NUM_SQ       = 2
);
    logic                              issue_valid;
    logic [NUM_RD_PORTS*REGNOBITS-1:0] issue_rs_no;
    logic [NUM_RD_PORTS-1:0]           issue_rs_used;
    logic                              issue_wr;
    logic [REGNOBITS-1:0]              issue_rd;
    logic                              stall;
    logic [NUM_RD_PORTS*DBITS-1:0]     rs_val;
    logic                              wb_valid;
    logic [REGNOBITS-1:0]              wb_regno;
    logic [DBITS-1:0]                  wb_data;
    logic [NUM_SQ-1:0]                 squash_valid;
    logic [NUM_SQ*REGNOBITS-1:0]       squash_regno;
    logic                              pending_any;
    logic                              err;

    modport master (
        output issue_valid, issue_rs_no, issue_rs_used, issue_wr, issue_rd,
        output wb_valid, wb_regno, wb_data, squash_valid, squash_regno,
        input  stall, rs_val, pending_any, err
    );

    modport slave (
        input  issue_valid, issue_rs_no, issue_rs_used, issue_wr, issue_rd,
        input  wb_valid, wb_regno, wb_data, squash_valid, squash_regno,
        output stall, rs_val, pending_any, err
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Architectural register file with exact per-register pending-write counters,
// same-cycle writeback bypass on every read port, and squash ports.
module regfile_scoreboard #(
    parameter int DBITS        = 32,
    parameter int REGWORDS     = 32,
    parameter int REGNOBITS    = 5,
    parameter int NUM_RD_PORTS = 2,
    parameter int MAX_INFLIGHT = 3,
    parameter int NUM_SQ       = 2
) (
    input logic                 clk,
    input logic                 reset,
    regfile_scoreboard_if.slave bus
);
    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_INFLIGHT);

    logic [DBITS-1:0]              regs_q [REGWORDS];
    logic [DBITS-1:0]              regs_d [REGWORDS];
    logic [CW-1:0]                 cnt_q  [REGWORDS];
    logic [CW-1:0]                 cnt_d  [REGWORDS];
    logic                          err_q;
    logic                          err_d;
    logic                          stall_c;
    logic                          accept;
    logic                          pending_c;
    logic [NUM_RD_PORTS*DBITS-1:0] rs_val_c;

    // A source held only by the write retiring this cycle is ready via the bypass.
    always_comb begin
        rs_val_c = '0;
        stall_c  = 1'b0;
        for (int i = 0; i < NUM_RD_PORTS; i++) begin
            automatic logic [REGNOBITS-1:0] rs = bus.issue_rs_no[i*REGNOBITS +: REGNOBITS];
            automatic logic wb_hit = bus.wb_valid && (bus.wb_regno == rs);
            if (rs != '0) begin
                rs_val_c[i*DBITS +: DBITS] = wb_hit ? bus.wb_data : regs_q[rs];
            end
            if (bus.issue_rs_used[i] && (rs != '0) && (cnt_q[rs] != '0) &&
                !((cnt_q[rs] == CW'(1)) && wb_hit)) begin
                stall_c = 1'b1;
            end
        end
        if (bus.issue_wr && (bus.issue_rd != '0) && (cnt_q[bus.issue_rd] == CNT_MAX)) begin
            stall_c = 1'b1;
        end
        stall_c = stall_c && bus.issue_valid;
    end

    assign accept = bus.issue_valid && !stall_c;

    always_comb begin
        regs_d = regs_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        if (bus.wb_valid && (bus.wb_regno != '0)) begin
            regs_d[bus.wb_regno] = bus.wb_data;
        end
        for (int r = 1; r < REGWORDS; r++) begin
            automatic int up    = 0;
            automatic int down  = 0;
            automatic int total = 0;
            if (accept && bus.issue_wr && (bus.issue_rd == REGNOBITS'(r))) up = 1;
            if (bus.wb_valid && (bus.wb_regno == REGNOBITS'(r))) down = 1;
            for (int j = 0; j < NUM_SQ; j++) begin
                if (bus.squash_valid[j] &&
                    (bus.squash_regno[j*REGNOBITS +: REGNOBITS] == REGNOBITS'(r))) begin
                    down = down + 1;
                end
            end
            total = int'(cnt_q[r]) + up - down;
            // Underflow clamps to zero, overflow saturates; both are sticky errors.
            if (total < 0) begin
                cnt_d[r] = '0;
                err_d    = 1'b1;
            end else if (total > MAX_INFLIGHT) begin
                cnt_d[r] = CNT_MAX;
                err_d    = 1'b1;
            end else begin
                cnt_d[r] = CW'(total);
            end
        end
    end

    always_comb begin
        pending_c = 1'b0;
        for (int r = 0; r < REGWORDS; r++) begin
            if (cnt_q[r] != '0) pending_c = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < REGWORDS; r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
            err_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign bus.stall       = stall_c;
    assign bus.rs_val      = rs_val_c;
    assign bus.pending_any = pending_c;
    assign bus.err         = err_q;
endmodule
